hamming_secded_stream_dec: RTL

HAMMING_SECDED_STREAM_DEC -- requirements
Module: hamming_secded_stream_dec

---
 rtl/hamming_secded_stream_dec.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hamming_secded_stream_dec.sv
// Purpose: streaming SECDED (extended Hamming) decoder with optional single-bit correction and saturating error counters.
// Latency: 2 cycles from accept to out_valid (syndrome stage, then classify/correct stage).
// Backpressure: valid/ready on both sides; in_ready drops only when both stages are full and out_ready is low.
module hamming_secded_stream_dec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  // Smallest r with 2^r >= DATA_W+r+1, written out for the legal 4..57 range.
  localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              single_error,
  output logic              double_error,
  output logic [PAR_W:0]    err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt
);

  // Highest real Hamming position; syndromes above it cannot be a single error.
  localparam logic [PAR_W:0] LAST_POS = (PAR_W+1)'(CODE_W - 1);
  // Reported position for an error on the overall parity bit (code_in[0]).
  localparam logic [PAR_W:0] OVR_POS  = {1'b1, {PAR_W{1'b0}}};

  // Hamming position of the k-th data bit (k-th non-power-of-two position).
  function automatic int data_pos(input int k);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int j = 3; j < CODE_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (n == k) res = j;
        n++;
      end
    end
    return res;
  endfunction

  // Stage 1 state: only the data bits of the codeword are kept, since the
  // parity bits are fully consumed by the syndrome and overall parity.
  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;
  logic              s1_cen;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_ovr;

  logic [PAR_W-1:0]  syn_c;
  logic              ovr_c;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] dec_data;

  logic              s2_adv;
  logic              xfer;
  logic              syn_nz;
  logic              syn_big;
  logic              single_c;
  logic              double_c;
  logic              fix_en;
  logic [PAR_W:0]    pos_c;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !(s1_vld && out_valid && !out_ready);
  assign xfer     = out_valid && out_ready;

  // Syndrome: bit i is the parity of all positions whose index has bit i set.
  always_comb begin
    syn_c = '0;
    for (int j = 1; j < CODE_W; j++) begin
      for (int i = 0; i < PAR_W; i++) begin
        if (((j >> i) & 1) != 0) syn_c[i] = syn_c[i] ^ code_in[j];
      end
    end
  end

  assign ovr_c = ^code_in;

  // Data bit gather and (optional) correction: a data bit flips only when the
  // syndrome names its own position.
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int P = data_pos(k);
    assign raw_c[k]    = code_in[P];
    assign dec_data[k] = s1_data[k] ^ (fix_en && (s1_syn == PAR_W'(P)));
  end

  // Classify the stage-1 word into none / single / double.
  always_comb begin
    syn_nz   = |s1_syn;
    syn_big  = {1'b0, s1_syn} > LAST_POS;
    single_c = s1_ovr && !syn_big;
    double_c = (syn_nz && !s1_ovr) || (s1_ovr && syn_big);
    fix_en   = single_c && s1_cen;
    pos_c    = '0;
    if (single_c) pos_c = syn_nz ? {1'b0, s1_syn} : OVR_POS;
  end

  // Stage 1 register: loads whenever there is room, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_cen  <= 1'b0;
      s1_syn  <= '0;
      s1_ovr  <= 1'b0;
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_data <= raw_c;
        s1_cen  <= correct_en;
        s1_syn  <= syn_c;
        s1_ovr  <= ovr_c;
      end
    end
  end

  // Stage 2 register: output slot, frozen while the result is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      data_out     <= '0;
      single_error <= 1'b0;
      double_error <= 1'b0;
      err_pos      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        data_out     <= dec_data;
        single_error <= single_c;
        double_error <= double_c;
        err_pos      <= pos_c;
      end
    end
  end

  // Error counters: count per transferred result, saturate, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (cnt_clr) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (xfer) begin
      if (single_error && (single_cnt != '1)) single_cnt <= single_cnt + 1'b1;
      if (double_error && (double_cnt != '1)) double_cnt <= double_cnt + 1'b1;
    end
  end

endmodule
